window_loader: RTL and testbench

WINDOW_LOADER -- requirements
Module: window_loader

---
 rtl/window_loader.sv | 162 ++++++++++++++++
 tb/tb_window_loader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/window_loader.sv
// window_loader: builds a SIZE x SIZE pixel window from a raster-order stream
// using SIZE-1 line buffers, then hands each complete window to a convolution
// stage through a clear/start/done handshake.
// Optional feature: define WINDOW_LOADER_COORD_EN to add win_x/win_y ports
// reporting the centre of the window currently presented.
module window_loader #(
   parameter logic [3:0]  SIZE  = 4'd3,
   parameter logic [15:0] IMG_W = 16'd64,
   parameter logic [15:0] IMG_H = 16'd64
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [7:0]                   pix_in,
   input  logic                         pix_valid,
   input  logic                         pix_sof,
   output logic                         pix_ready,
   output logic [SIZE-1:0][SIZE-1:0][7:0] input_matrix,
   output logic                         conv_clear,
   output logic                         conv_start,
   input  logic                         conv_done,
   output logic                         frame_done
`ifdef WINDOW_LOADER_COORD_EN
   ,
   output logic [15:0]                  win_x,
   output logic [15:0]                  win_y
`endif
);

   localparam int unsigned N      = 32'(SIZE);
   localparam int unsigned W      = 32'(IMG_W);
   localparam int unsigned XW     = (W > 1) ? $clog2(W) : 1;
   localparam logic [15:0] EDGE   = 16'(SIZE) - 16'd1;
   localparam logic [15:0] X_LAST = IMG_W - 16'd1;
   localparam logic [15:0] Y_LAST = IMG_H - 16'd1;
`ifdef WINDOW_LOADER_COORD_EN
   localparam logic [15:0] HALF   = EDGE >> 1;
`endif

   typedef enum logic [1:0] {S_ACCEPT, S_CLEAR, S_START, S_WAIT} state_t;

   state_t               state;
   logic [15:0]          x;
   logic [15:0]          y;
   logic [15:0]          cur_x;
   logic [15:0]          cur_y;
   logic                 ready_q;
   logic                 clear_q;
   logic                 start_q;
   logic                 done_q;
   logic                 last_q;
   logic                 accept;
   logic                 win_hit;
   logic [XW-1:0]        col_idx;
   logic [SIZE-1:0][7:0] new_col;
   // line_buf[0] holds row y-1, line_buf[k] holds row y-1-k
   logic [7:0]           line_buf [0:N-2][0:W-1];

   // Outputs are held low combinationally while reset is asserted.
   assign pix_ready  = ready_q & ~rst;
   assign conv_clear = clear_q & ~rst;
   assign conv_start = start_q & ~rst;
   assign frame_done = done_q  & ~rst;

   // Coordinates of the pixel being offered (SOF forces 0,0) and the new window column.
   always_comb begin
      cur_x   = pix_sof ? '0 : x;
      cur_y   = pix_sof ? '0 : y;
      accept  = pix_valid && pix_ready;
      win_hit = (cur_x >= EDGE) && (cur_y >= EDGE);
      col_idx = cur_x[XW-1:0];
      new_col = '0;
      new_col[N-1] = pix_in;
      for (int unsigned k = 0; k < N - 1; k++) begin
         new_col[N-2-k] = line_buf[k][col_idx];
      end
   end

   // Shift window left by one column and push the pixel down the line buffers.
   always_ff @(posedge clk) begin
      if (rst) begin
         input_matrix <= '0;
         for (int unsigned k = 0; k < N - 1; k++) begin
            for (int unsigned i = 0; i < W; i++) begin
               line_buf[k][i] <= '0;
            end
         end
      end else if (accept) begin
         for (int unsigned r = 0; r < N; r++) begin
            for (int unsigned c = 0; c < N - 1; c++) begin
               input_matrix[r][c] <= input_matrix[r][c+1];
            end
            input_matrix[r][N-1] <= new_col[r];
         end
         line_buf[0][col_idx] <= pix_in;
         for (int unsigned k = 1; k < N - 1; k++) begin
            line_buf[k][col_idx] <= line_buf[k-1][col_idx];
         end
      end
   end

   // Handshake FSM with raster counters; pulse outputs default low every cycle.
   always_ff @(posedge clk) begin
      clear_q <= 1'b0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      if (rst) begin
         state   <= S_ACCEPT;
         x       <= '0;
         y       <= '0;
         ready_q <= 1'b1;
         last_q  <= 1'b0;
`ifdef WINDOW_LOADER_COORD_EN
         win_x   <= '0;
         win_y   <= '0;
`endif
      end else begin
         case (state)
            S_ACCEPT: begin
               if (accept) begin
                  if (cur_x == X_LAST) begin
                     x <= '0;
                     y <= (cur_y == Y_LAST) ? '0 : cur_y + 16'd1;
                  end else begin
                     x <= cur_x + 16'd1;
                     y <= cur_y;
                  end
                  if (win_hit) begin
                     state   <= S_CLEAR;
                     clear_q <= 1'b1;
                     ready_q <= 1'b0;
                     last_q  <= (cur_x == X_LAST) && (cur_y == Y_LAST);
`ifdef WINDOW_LOADER_COORD_EN
                     win_x   <= cur_x - HALF;
                     win_y   <= cur_y - HALF;
`endif
                  end
               end
            end
            S_CLEAR: begin
               state   <= S_START;
               start_q <= 1'b1;
            end
            S_START: begin
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (conv_done) begin
                  state   <= S_ACCEPT;
                  ready_q <= 1'b1;
                  if (last_q) begin
                     done_q <= 1'b1;
                     x      <= '0;
                     y      <= '0;
                  end
               end
            end
            default: state <= S_ACCEPT;
         endcase
      end
   end

endmodule

// File: tb/tb_window_loader.sv
// Testbench for window_loader: SIZE=3 on a 4x4 frame, pixel value = base + 4y + x,
// conv_done returned 3 cycles after each conv_start.
module tb_window_loader;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [7:0]            pix_in = '0;
   logic                  pix_valid = 1'b0;
   logic                  pix_sof = 1'b0;
   logic                  pix_ready;
   logic [2:0][2:0][7:0]  input_matrix;
   logic                  conv_clear;
   logic                  conv_start;
   logic                  conv_done;
   logic                  frame_done;
`ifdef WINDOW_LOADER_COORD_EN
   logic [15:0]           win_x;
   logic [15:0]           win_y;
`endif

   typedef struct {
      logic [71:0] mat;
      logic [15:0] wx;
      logic [15:0] wy;
   } win_t;

   logic [2:0] dly = '0;
   int         n_checks = 0;
   int         n_fail = 0;
   int         n_start = 0;
   int         n_fd = 0;
   win_t       cap [$];
   win_t       mon_w;
   win_t       tbl [4];
   logic [3:0] seq_exp [6];   // {pix_ready, conv_clear, conv_start, conv_done}

   window_loader #(
      .SIZE  (4'd3),
      .IMG_W (16'd4),
      .IMG_H (16'd4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .pix_in       (pix_in),
      .pix_valid    (pix_valid),
      .pix_sof      (pix_sof),
      .pix_ready    (pix_ready),
      .input_matrix (input_matrix),
      .conv_clear   (conv_clear),
      .conv_start   (conv_start),
      .conv_done    (conv_done),
      .frame_done   (frame_done)
`ifdef WINDOW_LOADER_COORD_EN
      ,
      .win_x        (win_x),
      .win_y        (win_y)
`endif
   );

   always #5 clk = ~clk;

   // Convolution stage stand-in: conv_done three cycles after conv_start.
   always @(posedge clk) begin
      if (rst) dly <= '0;
      else     dly <= {dly[1:0], conv_start};
   end
   assign conv_done = dly[2];

   // Monitor: count pulses and capture each window while conv_clear is high.
   always @(negedge clk) begin
      if (conv_start) n_start <= n_start + 1;
      if (frame_done) n_fd <= n_fd + 1;
      if (conv_clear) begin
         mon_w.mat = input_matrix;
`ifdef WINDOW_LOADER_COORD_EN
         mon_w.wx = win_x;
         mon_w.wy = win_y;
`else
         mon_w.wx = '0;
         mon_w.wy = '0;
`endif
         cap.push_back(mon_w);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, required test completion");
      $fatal(1);
   end

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic send_px(input logic [7:0] v, input logic sof);
      int t;
      t = 0;
      @(negedge clk);
      while (!pix_ready && t < 40) begin
         @(negedge clk);
         t++;
      end
      if (!pix_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL accept_timeout: pix_ready=%b, required 1", pix_ready);
      end
      pix_in    = v;
      pix_sof   = sof;
      pix_valid = 1'b1;
      @(posedge clk);
      #1;
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
   endtask

   task automatic stream_frame(input logic [7:0] base);
      for (int i = 0; i < 16; i++) send_px(base + 8'(i), i == 0);
   endtask

   function automatic win_t cap_at(input int i);
      win_t w;
      w.mat = 'x;
      w.wx  = 'x;
      w.wy  = 'x;
      if (i < cap.size()) w = cap[i];
      return w;
   endfunction

   function automatic logic [71:0] add_base(input logic [71:0] m, input logic [7:0] b);
      logic [71:0] r;
      for (int i = 0; i < 9; i++) r[i*8 +: 8] = m[i*8 +: 8] + b;
      return r;
   endfunction

   initial begin
      int base_c;
      int base_s;
      int base_fd;
      win_t w;

      // Windows in issue order; packed as {[2][2],[2][1],...,[0][0]}.
      tbl[0] = '{mat: {8'd10, 8'd9,  8'd8,  8'd6,  8'd5,  8'd4, 8'd2, 8'd1, 8'd0}, wx: 16'd1, wy: 16'd1};
      tbl[1] = '{mat: {8'd11, 8'd10, 8'd9,  8'd7,  8'd6,  8'd5, 8'd3, 8'd2, 8'd1}, wx: 16'd2, wy: 16'd1};
      tbl[2] = '{mat: {8'd14, 8'd13, 8'd12, 8'd10, 8'd9,  8'd8, 8'd6, 8'd5, 8'd4}, wx: 16'd1, wy: 16'd2};
      tbl[3] = '{mat: {8'd15, 8'd14, 8'd13, 8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5}, wx: 16'd2, wy: 16'd2};
      seq_exp = '{4'b0100, 4'b0010, 4'b0000, 4'b0000, 4'b0001, 4'b1000};

      // Reset state
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_pix_ready",  72'(pix_ready),  72'd0);
      check("rst_conv_clear", 72'(conv_clear), 72'd0);
      check("rst_conv_start", 72'(conv_start), 72'd0);
      check("rst_frame_done", 72'(frame_done), 72'd0);
      check("rst_matrix",     72'(input_matrix), 72'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("ready_after_rst", 72'(pix_ready), 72'd1);

      // Frame 1 with handshake timing and frame_done checks
      base_c  = cap.size();
      base_s  = n_start;
      base_fd = n_fd;
      for (int i = 0; i < 16; i++) begin
         send_px(8'(i), i == 0);
         if (i == 10) begin
            for (int k = 0; k < 6; k++) begin
               @(negedge clk);
               check("hs_timing", 72'({pix_ready, conv_clear, conv_start, conv_done}), 72'(seq_exp[k]));
            end
         end
         if (i == 15) begin
            for (int k = 0; k < 8; k++) begin
               @(negedge clk);
               check("frame_done_pulse", 72'(frame_done), 72'(k == 5));
            end
         end
      end
      check("f1_start_count", 72'(n_start - base_s), 72'd4);
      check("f1_fd_count",    72'(n_fd - base_fd),   72'd1);
      for (int i = 0; i < 4; i++) begin
         w = cap_at(base_c + i);
         check("f1_window", w.mat, tbl[i].mat);
`ifdef WINDOW_LOADER_COORD_EN
         check("f1_win_x", 72'(w.wx), 72'(tbl[i].wx));
         check("f1_win_y", 72'(w.wy), 72'(tbl[i].wy));
`endif
      end

      // Frame 2 directly after frame_done
      base_c  = cap.size();
      base_fd = n_fd;
      stream_frame(8'd0);
      repeat (10) @(negedge clk);
      w = cap_at(base_c);
      check("f2_first_window", w.mat, tbl[0].mat);
      check("f2_fd_count", 72'(n_fd - base_fd), 72'd1);

      // Reset while waiting for conv_done
      for (int i = 0; i < 11; i++) send_px(8'(i), i == 0);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      base_s = n_start;
      @(negedge clk);
      check("midrst_pix_ready",  72'(pix_ready),  72'd0);
      check("midrst_conv_start", 72'(conv_start), 72'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      check("midrst_no_start", 72'(n_start - base_s), 72'd0);
      base_c = cap.size();
      base_s = n_start;
      stream_frame(8'd0);
      repeat (10) @(negedge clk);
      check("midrst_start_count", 72'(n_start - base_s), 72'd4);
      w = cap_at(base_c);
      check("midrst_first_window", w.mat, tbl[0].mat);

      // SOF arriving at old position (1,2) resyncs to a new frame
      base_s = n_start;
      for (int i = 0; i < 9; i++) send_px(8'(i), i == 0);
      repeat (3) @(negedge clk);
      check("sof_prefix_no_start", 72'(n_start - base_s), 72'd0);
      base_c = cap.size();
      base_s = n_start;
      stream_frame(8'd100);
      repeat (10) @(negedge clk);
      check("sof_start_count", 72'(n_start - base_s), 72'd4);
      for (int i = 0; i < 4; i++) begin
         w = cap_at(base_c + i);
         check("sof_window", w.mat, add_base(tbl[i].mat, 8'd100));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
